// File: rtl/jtag_tap_responder.sv
// Target-side JTAG TAP: 16-state controller, IR, BYPASS/IDCODE/USER DRs.
// Define JTAG_TAP_USER_DR_EN to build the USER data register.
module jtag_tap_responder #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1A5E_0093,
  parameter int          USER_DR_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tms,
  input  logic                     tdi,
  output logic                     tdo,
  output logic                     tdo_en,
  output logic [3:0]               tap_state,
  output logic [IR_WIDTH-1:0]      ir_out,
  input  logic [USER_DR_WIDTH-1:0] user_dr_in,
  output logic [USER_DR_WIDTH-1:0] user_dr_out,
  output logic                     update_pulse
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI      = 4'd1,
    SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,
    PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR   = 4'd9,
    CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12, PAUSE_IR = 4'd13,
    EXIT2_IR = 4'd14, UPD_IR   = 4'd15
  } state_e;

  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] OP_USER   =
    {1'b1, {(IR_WIDTH-1){1'b0}}};

  state_e                state_q;
  logic [IR_WIDTH-1:0]   ir_q;
  logic [IR_WIDTH-1:0]   ir_sr_q;
  logic                  bypass_q;
  logic [31:0]           id_sr_q;
  logic                  sel_id;
  logic                  sel_user;
  logic                  user_lsb;

  function automatic state_e next_state(state_e s, logic m);
    case (s)
      TLR:      return m ? TLR      : RTI;
      RTI:      return m ? SEL_DR   : RTI;
      SEL_DR:   return m ? SEL_IR   : CAP_DR;
      CAP_DR:   return m ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: return m ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: return m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: return m ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: return m ? UPD_DR   : SHIFT_DR;
      UPD_DR:   return m ? SEL_DR   : RTI;
      SEL_IR:   return m ? TLR      : CAP_IR;
      CAP_IR:   return m ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: return m ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: return m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: return m ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: return m ? UPD_IR   : SHIFT_IR;
      default:  return m ? SEL_DR   : RTI;
    endcase
  endfunction

  // Anything not IDCODE or (enabled) USER falls through to BYPASS.
  assign sel_id = (ir_q == OP_IDCODE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= TLR;
      ir_q     <= OP_IDCODE;
      ir_sr_q  <= '0;
      bypass_q <= 1'b0;
      id_sr_q  <= '0;
    end else begin
      state_q <= next_state(state_q, tms);
      case (state_q)
        TLR:      ir_q    <= OP_IDCODE;
        CAP_IR:   ir_sr_q <= IR_WIDTH'(2'b01);
        SHIFT_IR: ir_sr_q <= {tdi, ir_sr_q[IR_WIDTH-1:1]};
        UPD_IR:   ir_q    <= ir_sr_q;
        CAP_DR: begin
          if (sel_id)         id_sr_q  <= IDCODE_VALUE;
          else if (!sel_user) bypass_q <= 1'b0;
        end
        SHIFT_DR: begin
          if (sel_id)         id_sr_q  <= {tdi, id_sr_q[31:1]};
          else if (!sel_user) bypass_q <= tdi;
        end
        default: ;
      endcase
    end
  end

`ifdef JTAG_TAP_USER_DR_EN
  logic [USER_DR_WIDTH-1:0] user_sr_q;
  logic [USER_DR_WIDTH-1:0] user_out_q;
  logic                     pulse_q;

  assign sel_user = (ir_q == OP_USER);
  assign user_lsb = user_sr_q[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      user_sr_q  <= '0;
      user_out_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      if (sel_user) begin
        case (state_q)
          CAP_DR:   user_sr_q <= user_dr_in;
          SHIFT_DR: user_sr_q <= (user_sr_q >> 1) |
                      (USER_DR_WIDTH'(tdi) << (USER_DR_WIDTH-1));
          UPD_DR: begin
            user_out_q <= user_sr_q;
            pulse_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign user_dr_out  = user_out_q;
  assign update_pulse = pulse_q;
`else
  logic unused_user_in;

  assign unused_user_in = ^user_dr_in;
  assign sel_user       = 1'b0;
  assign user_lsb       = 1'b0;
  assign user_dr_out    = '0;
  assign update_pulse   = 1'b0;
`endif

  always_comb begin
    tdo = 1'b0;
    if (state_q == SHIFT_IR)
      tdo = ir_sr_q[0];
    else if (state_q == SHIFT_DR)
      tdo = sel_id ? id_sr_q[0] : (sel_user ? user_lsb : bypass_q);
  end

  assign tdo_en    = (state_q == SHIFT_DR) || (state_q == SHIFT_IR);
  assign tap_state = state_q;
  assign ir_out    = ir_q;

endmodule

// File: tb/tb_jtag_tap_responder.sv
// Directed bench for jtag_tap_responder; follows JTAG_TAP_USER_DR_EN.
// Inputs change and outputs are sampled on the falling edge of TCK.
module tb_jtag_tap_responder;

  logic       clk;
  logic       rst;
  logic       tms;
  logic       tdi;
  logic       tdo;
  logic       tdo_en;
  logic [3:0] tap_state;
  logic [3:0] ir_out;
  logic [7:0] user_dr_in;
  logic [7:0] user_dr_out;
  logic       update_pulse;

  int checks;
  int errors;
  int pulse_cnt;
  logic last_tdo;

  jtag_tap_responder #(
    .IR_WIDTH      (4),
    .IDCODE_VALUE  (32'h1A5E_0093),
    .USER_DR_WIDTH (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tms          (tms),
    .tdi          (tdi),
    .tdo          (tdo),
    .tdo_en       (tdo_en),
    .tap_state    (tap_state),
    .ir_out       (ir_out),
    .user_dr_in   (user_dr_in),
    .user_dr_out  (user_dr_out),
    .update_pulse (update_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk)
    if (update_pulse === 1'b1) pulse_cnt++;

  task automatic tick(input logic m, input logic d);
    tms = m;
    tdi = d;
    last_tdo = tdo;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic shift_bits(input logic [31:0] data, input int n,
                            output logic [31:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1, data[i]);
      got[i] = last_tdo;
    end
  endtask

  task automatic load_ir(input logic [3:0] op);
    logic [31:0] junk;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_bits({28'h0, op}, 4, junk);
    tick(1, 0); tick(0, 0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(1, 0); tick(1, 0);
    rst = 1'b0;
    checks++;
    if (tap_state !== 4'd0 || ir_out !== 4'b0001 || tdo_en !== 1'b0 ||
        tdo !== 1'b0 || user_dr_out !== 8'h00 || update_pulse !== 1'b0) begin
      errors++;
      $display("FAIL reset: state=%0d ir=%b en=%b tdo=%b uout=%h up=%b want 0 0001 0 0 00 0",
               tap_state, ir_out, tdo_en, tdo, user_dr_out, update_pulse);
    end
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    checks++;
    if (tap_state !== 4'd4 || tdo_en !== 1'b1) begin
      errors++;
      $display("FAIL enter_shift_dr: state=%0d en=%b want 4 1", tap_state, tdo_en);
    end
    for (int i = 0; i < 5; i++) tick(1, 0);
    checks++;
    if (tap_state !== 4'd0 || ir_out !== 4'b0001 || tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL tms5_tlr: state=%0d ir=%b en=%b want 0 0001 0",
               tap_state, ir_out, tdo_en);
    end
  endtask

  task automatic test_idcode;
    logic [31:0] got;
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    shift_bits(32'h0, 32, got);
    checks++;
    if (got !== 32'h1A5E_0093) begin
      errors++;
      $display("FAIL idcode: got %h want 1a5e0093", got);
    end
    checks++;
    if (tap_state !== 4'd5) begin
      errors++;
      $display("FAIL idcode_exit1: state=%0d want 5", tap_state);
    end
    tick(1, 0); tick(0, 0);
    checks++;
    if (tap_state !== 4'd1) begin
      errors++;
      $display("FAIL idcode_rti: state=%0d want 1", tap_state);
    end
  endtask

  task automatic test_ir_load;
    logic [31:0] got;
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    checks++;
    if (tap_state !== 4'd11 || tdo_en !== 1'b1) begin
      errors++;
      $display("FAIL shift_ir_state: state=%0d en=%b want 11 1", tap_state, tdo_en);
    end
    shift_bits(32'hF, 4, got);
    checks++;
    if (got[3:0] !== 4'b0001) begin
      errors++;
      $display("FAIL ir_capture: got %b want 0001", got[3:0]);
    end
    tick(1, 0);
    checks++;
    if (tap_state !== 4'd15 || ir_out !== 4'b0001) begin
      errors++;
      $display("FAIL upd_ir_pre: state=%0d ir=%b want 15 0001", tap_state, ir_out);
    end
    tick(0, 0);
    checks++;
    if (ir_out !== 4'b1111 || tap_state !== 4'd1) begin
      errors++;
      $display("FAIL ir_load: ir=%b state=%0d want 1111 1", ir_out, tap_state);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] got;
    int p0;
    p0 = pulse_cnt;
    tick(1, 0); tick(0, 0); tick(0, 0);
    shift_bits(32'b1101, 4, got);
    checks++;
    if (got[3:0] !== 4'b1010) begin
      errors++;
      $display("FAIL bypass: got %b want 1010", got[3:0]);
    end
    tick(1, 0); tick(0, 0); tick(0, 0);
    checks++;
    if (pulse_cnt !== p0 || user_dr_out !== 8'h00) begin
      errors++;
      $display("FAIL bypass_upd: pulses=%0d uout=%h want 0 00",
               pulse_cnt - p0, user_dr_out);
    end
  endtask

  task automatic test_user;
    logic [31:0] lo;
    logic [31:0] hi;
    logic [7:0]  tdo_got;
    logic [7:0]  exp_tdo;
    logic [7:0]  exp_out;
    int          exp_pulse;
    int          p0;
`ifdef JTAG_TAP_USER_DR_EN
    exp_tdo   = 8'h3C;
    exp_out   = 8'hA5;
    exp_pulse = 1;
`else
    exp_tdo   = 8'h4A;
    exp_out   = 8'h00;
    exp_pulse = 0;
`endif
    load_ir(4'b1000);
    checks++;
    if (ir_out !== 4'b1000) begin
      errors++;
      $display("FAIL user_ir: ir=%b want 1000", ir_out);
    end
    user_dr_in = 8'h3C;
    p0 = pulse_cnt;
    tick(1, 0); tick(0, 0); tick(0, 0);
    shift_bits(32'h5, 4, lo);
    tick(0, 0);
    for (int i = 0; i < 10; i++) tick(0, 0);
    checks++;
    if (tap_state !== 4'd6 || tdo_en !== 1'b0) begin
      errors++;
      $display("FAIL pause_state: state=%0d en=%b want 6 0", tap_state, tdo_en);
    end
    tick(1, 0); tick(0, 0);
    shift_bits(32'hA, 4, hi);
    tdo_got = {hi[3:0], lo[3:0]};
    checks++;
    if (tdo_got !== exp_tdo) begin
      errors++;
      $display("FAIL user_tdo: got %h want %h", tdo_got, exp_tdo);
    end
    tick(1, 0);
    checks++;
    if (tap_state !== 4'd8 || update_pulse !== 1'b0 || user_dr_out !== 8'h00) begin
      errors++;
      $display("FAIL upd_dr_pre: state=%0d up=%b uout=%h want 8 0 00",
               tap_state, update_pulse, user_dr_out);
    end
    tick(0, 0);
    checks++;
    if (user_dr_out !== exp_out || update_pulse !== (exp_pulse == 1)) begin
      errors++;
      $display("FAIL user_update: uout=%h up=%b want %h %0d",
               user_dr_out, update_pulse, exp_out, exp_pulse);
    end
    tick(0, 0);
    checks++;
    if (update_pulse !== 1'b0 || pulse_cnt - p0 !== exp_pulse) begin
      errors++;
      $display("FAIL pulse_width: up=%b pulses=%0d want 0 %0d",
               update_pulse, pulse_cnt - p0, exp_pulse);
    end
  endtask

  task automatic test_reset_midshift;
    logic [31:0] junk;
    int p0;
    p0 = pulse_cnt;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) tick(0, i[0]);
    rst = 1'b1;
    tick(1, 0);
    rst = 1'b0;
    checks++;
    if (tap_state !== 4'd0 || ir_out !== 4'b0001 || tdo_en !== 1'b0 ||
        user_dr_out !== 8'h00 || pulse_cnt !== p0) begin
      errors++;
      $display("FAIL rst_midshift: state=%0d ir=%b en=%b uout=%h pulses=%0d want 0 0001 0 00 0",
               tap_state, ir_out, tdo_en, user_dr_out, pulse_cnt - p0);
    end
    tick(0, 0); tick(0, 0);
    checks++;
    if (update_pulse !== 1'b0 || pulse_cnt !== p0 || tap_state !== 4'd1) begin
      errors++;
      $display("FAIL rst_nopulse: up=%b pulses=%0d state=%0d want 0 0 1",
               update_pulse, pulse_cnt - p0, tap_state);
    end
    junk = '0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    pulse_cnt  = 0;
    last_tdo   = 1'b0;
    rst        = 1'b1;
    tms        = 1'b1;
    tdi        = 1'b0;
    user_dr_in = 8'h00;
    @(negedge clk);
    test_reset;
    test_idcode;
    test_ir_load;
    test_bypass;
    test_user;
    test_reset_midshift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
